// File: rtl/wb_regfile.sv
// wb_regfile: writeback select plus register file with two bypassed read ports and a commit counter
module wb_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  inResult,
  input  logic [DATA_WIDTH-1:0]  inReadData,
  input  logic [ADDR_WIDTH-1:0]  inRd,
  input  logic                   inMemToReg,
  input  logic                   inRegWrite,
  input  logic [ADDR_WIDTH-1:0]  rs,
  input  logic [ADDR_WIDTH-1:0]  rt,
  output logic [DATA_WIDTH-1:0]  outReadData1,
  output logic [DATA_WIDTH-1:0]  outReadData2,
  output logic [DATA_WIDTH-1:0]  outWriteData,
  output logic [ADDR_WIDTH-1:0]  outWriteReg,
  output logic                   outWriteEn,
  output logic [COUNT_WIDTH-1:0] outCommitCnt
);
  localparam int N = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [N];
  assign outWriteData = inMemToReg ? inReadData : inResult;
  assign outWriteReg  = inRd;
  assign outWriteEn   = inRegWrite && (inRd != '0) && !reset;
  // outWriteEn already excludes reset, so bypass is off while reset is held
  always_comb begin
    outReadData1 = (rs == '0) ? '0 : (outWriteEn && rs == inRd) ? outWriteData : regs[rs];
    outReadData2 = (rt == '0) ? '0 : (outWriteEn && rt == inRd) ? outWriteData : regs[rt];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      outCommitCnt <= '0;
    end else if (outWriteEn) begin
      regs[inRd]   <= outWriteData;
      outCommitCnt <= outCommitCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table plus hand sequences for reset/write collision and counter wrap
module tb_wb_regfile;
  logic        clock = 0;
  logic        reset;
  logic [31:0] inResult, inReadData;
  logic [4:0]  inRd, rs, rt;
  logic        inMemToReg, inRegWrite;
  logic [31:0] outReadData1, outReadData2, outWriteData, outCommitCnt;
  logic [4:0]  outWriteReg;
  logic        outWriteEn;
  logic [31:0] rd1_4, rd2_4, wd_4;
  logic [4:0]  wr_4;
  logic        we_4;
  logic [3:0]  cnt_4;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wb_regfile dut (
    .clock(clock), .reset(reset), .inResult(inResult), .inReadData(inReadData), .inRd(inRd),
    .inMemToReg(inMemToReg), .inRegWrite(inRegWrite), .rs(rs), .rt(rt),
    .outReadData1(outReadData1), .outReadData2(outReadData2), .outWriteData(outWriteData),
    .outWriteReg(outWriteReg), .outWriteEn(outWriteEn), .outCommitCnt(outCommitCnt)
  );

  wb_regfile #(.COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .inResult(inResult), .inReadData(inReadData), .inRd(inRd),
    .inMemToReg(inMemToReg), .inRegWrite(inRegWrite), .rs(rs), .rt(rt),
    .outReadData1(rd1_4), .outReadData2(rd2_4), .outWriteData(wd_4),
    .outWriteReg(wr_4), .outWriteEn(we_4), .outCommitCnt(cnt_4)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        mtr;
    logic        rw;
    logic [31:0] res;
    logic [31:0] rdat;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ewd;
    logic        ewe;
    logic [31:0] ecnt;
  } vec_t;

  vec_t v [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] d, input logic [31:0] res,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clock);
    reset = r; inRegWrite = w; inRd = d; inResult = res; inMemToReg = 0; inReadData = 0;
    rs = a1; rt = a2;
    #1;
  endtask

  initial begin
    v[0] = '{5'd5,  1'b0, 1'b1, 32'h1234, 32'h0,        5'd5, 5'd0,  32'h1234,     32'h0,        32'h1234,     1'b1, 32'd0};
    v[1] = '{5'd5,  1'b0, 1'b0, 32'h0,    32'h0,        5'd5, 5'd5,  32'h1234,     32'h1234,     32'h0,        1'b0, 32'd1};
    v[2] = '{5'd7,  1'b1, 1'b1, 32'h1,    32'hDEADBEEF, 5'd7, 5'd5,  32'hDEADBEEF, 32'h1234,     32'hDEADBEEF, 1'b1, 32'd1};
    v[3] = '{5'd0,  1'b0, 1'b1, 32'hFFFF, 32'h0,        5'd0, 5'd7,  32'h0,        32'hDEADBEEF, 32'hFFFF,     1'b0, 32'd2};
    v[4] = '{5'd9,  1'b0, 1'b1, 32'h55,   32'h0,        5'd9, 5'd9,  32'h55,       32'h55,       32'h55,       1'b1, 32'd2};
    v[5] = '{5'd9,  1'b0, 1'b1, 32'h77,   32'h0,        5'd9, 5'd10, 32'h77,       32'h0,        32'h77,       1'b1, 32'd3};
    v[6] = '{5'd9,  1'b0, 1'b0, 32'h0,    32'h0,        5'd9, 5'd7,  32'h77,       32'hDEADBEEF, 32'h0,        1'b0, 32'd4};
    v[7] = '{5'd5,  1'b1, 1'b1, 32'hBAD,  32'hCAFE,     5'd5, 5'd0,  32'hCAFE,     32'h0,        32'hCAFE,     1'b1, 32'd4};
    v[8] = '{5'd5,  1'b0, 1'b0, 32'h0,    32'h0,        5'd5, 5'd9,  32'hCAFE,     32'h77,       32'h0,        1'b0, 32'd5};

    reset = 1; inRegWrite = 0; inRd = 0; inResult = 0; inReadData = 0; inMemToReg = 0; rs = 0; rt = 0;
    @(negedge clock);
    reset = 0;
    #1;
    chk("reset_cnt", outCommitCnt, 32'd0);
    chk("reset_cnt4", {28'd0, cnt_4}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      rs = 5'(i); rt = 5'(31 - i + 1);
      #1;
      chk($sformatf("reset_r%0d", i), outReadData1, 32'd0);
      chk($sformatf("reset_rt%0d", 31 - i + 1), outReadData2, 32'd0);
    end

    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      inRd = v[k].rd; inMemToReg = v[k].mtr; inRegWrite = v[k].rw;
      inResult = v[k].res; inReadData = v[k].rdat; rs = v[k].a1; rt = v[k].a2;
      #1;
      chk($sformatf("v%0d_rd1", k), outReadData1, v[k].e1);
      chk($sformatf("v%0d_rd2", k), outReadData2, v[k].e2);
      chk($sformatf("v%0d_wd", k), outWriteData, v[k].ewd);
      chk($sformatf("v%0d_wreg", k), {27'd0, outWriteReg}, {27'd0, v[k].rd});
      chk($sformatf("v%0d_we", k), {31'd0, outWriteEn}, {31'd0, v[k].ewe});
      chk($sformatf("v%0d_cnt", k), outCommitCnt, v[k].ecnt);
    end

    drive(0, 1, 5'd3, 32'h11, 5'd3, 5'd5);
    drive(1, 1, 5'd3, 32'hAA, 5'd3, 5'd5);
    chk("rst_we", {31'd0, outWriteEn}, 32'd0);
    chk("rst_nobypass", outReadData1, 32'h11);
    chk("rst_r5_held", outReadData2, 32'hCAFE);
    drive(0, 0, 5'd3, 32'h0, 5'd3, 5'd5);
    chk("rst_r3", outReadData1, 32'd0);
    chk("rst_r5", outReadData2, 32'd0);
    chk("rst_cnt", outCommitCnt, 32'd0);
    chk("rst_cnt4", {28'd0, cnt_4}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 5'd1, 32'(i + 1), 5'd1, 5'd0);
      chk($sformatf("wrap_cnt4_%0d", i), {28'd0, cnt_4}, 32'(i));
    end
    drive(0, 0, 5'd1, 32'h0, 5'd1, 5'd0);
    chk("wrap_cnt4_final", {28'd0, cnt_4}, 32'd0);
    chk("wrap_cnt32", outCommitCnt, 32'd16);
    chk("wrap_r1", outReadData1, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
